// File: rtl/sram_arb_pkg.sv
// Shared types for the scratch-SRAM port arbiter.
// Port tag and per-stage valid/tag bundle.
package sram_arb_pkg;

  localparam int NUM_PORTS = 2;
  localparam int PORT_W = $clog2(NUM_PORTS);

  typedef logic [PORT_W-1:0] port_t;

  typedef struct packed {
    logic  vld;
    port_t tag;
  } stage_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way arbiter with per-port eligibility requests.
// SRAM_ARB_FIXED_PRIO_EN selects fixed priority (port 0 wins).
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

`ifdef SRAM_ARB_FIXED_PRIO_EN

  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ rst_n;

  // Port 0 always wins when it asks
  always_comb begin
    gnt_o = '0;
    if (req_i[0]) begin
      gnt_o[0] = 1'b1;
    end else if (req_i[1]) begin
      gnt_o[1] = 1'b1;
    end
  end

`else

  // ptr_q = 1 means port 1 is favoured
  logic ptr_q;
  logic ptr_d;

  // Pointer register, favours port 0 out of reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  // Grant favoured port on contention, then flip to the other
  always_comb begin
    gnt_o = '0;
    ptr_d = ptr_q;
    if (req_i[0] && (!req_i[1] || !ptr_q)) begin
      gnt_o[0] = 1'b1;
      ptr_d    = 1'b1;
    end else if (req_i[1]) begin
      gnt_o[1] = 1'b1;
      ptr_d    = 1'b0;
    end
  end

`endif

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one single-port scratch SRAM between two requesters.
// Build option: SRAM_ARB_FIXED_PRIO_EN (fixed priority arbitration).
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic                  req0_we,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_wdata,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic                  req1_we,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_wdata,
  output logic                  rsp0_valid,
  output logic [DATA_WIDTH-1:0] rsp0_rdata,
  output logic                  rsp1_valid,
  output logic [DATA_WIDTH-1:0] rsp1_rdata,
  output logic                  sram_cs,
  output logic                  sram_we,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [DATA_WIDTH-1:0] sram_din,
  input  logic [DATA_WIDTH-1:0] sram_dout,
  output logic                  busy
);

  stage_t s1_q, s1_d;
  stage_t s2_q, s2_d;
  stage_t s3_q, s3_d;

  logic                  cs_q, cs_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] din_q, din_d;
  logic [DATA_WIDTH-1:0] rd0_q, rd0_d;
  logic [DATA_WIDTH-1:0] rd1_q, rd1_d;

  logic [1:0]            elig;
  logic [1:0]            gnt;
  logic                  s1_rd;
  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;

  // A read sitting in S1 needs the next cycle to stay a read
  assign s1_rd = s1_q.vld & ~we_q;

  assign elig[0] = rst_n & req0_valid & (~req0_we | ~s1_rd);
  assign elig[1] = rst_n & req1_valid & (~req1_we | ~s1_rd);

  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req_i (elig),
    .gnt_o (gnt)
  );

  assign req0_ready = gnt[0];
  assign req1_ready = gnt[1];

  assign sel_we    = gnt[1] ? req1_we    : req0_we;
  assign sel_addr  = gnt[1] ? req1_addr  : req0_addr;
  assign sel_wdata = gnt[1] ? req1_wdata : req0_wdata;

  // S1 issue: new access, capture hold cycle, or idle bus
  always_comb begin
    s1_d   = '0;
    cs_d   = 1'b0;
    we_d   = 1'b0;
    addr_d = '0;
    din_d  = '0;
    if (|gnt) begin
      s1_d.vld = 1'b1;
      s1_d.tag = port_t'(gnt[1]);
      cs_d     = 1'b1;
      we_d     = sel_we;
      addr_d   = sel_addr;
      din_d    = sel_we ? sel_wdata : '0;
    end else if (s1_rd) begin
      cs_d   = 1'b1;
      addr_d = addr_q;
    end
  end

  // S2 capture and S3 respond bookkeeping
  always_comb begin
    s2_d.vld = s1_rd;
    s2_d.tag = s1_q.tag;
    s3_d     = s2_q;
    rd0_d    = rd0_q;
    rd1_d    = rd1_q;
    if (s2_q.vld && s2_q.tag == port_t'(0)) begin
      rd0_d = sram_dout;
    end
    if (s2_q.vld && s2_q.tag == port_t'(1)) begin
      rd1_d = sram_dout;
    end
  end

  // Pipeline registers, all cleared by reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q   <= '0;
      s2_q   <= '0;
      s3_q   <= '0;
      cs_q   <= 1'b0;
      we_q   <= 1'b0;
      addr_q <= '0;
      din_q  <= '0;
      rd0_q  <= '0;
      rd1_q  <= '0;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      s3_q   <= s3_d;
      cs_q   <= cs_d;
      we_q   <= we_d;
      addr_q <= addr_d;
      din_q  <= din_d;
      rd0_q  <= rd0_d;
      rd1_q  <= rd1_d;
    end
  end

  assign sram_cs    = cs_q;
  assign sram_we    = we_q;
  assign sram_addr  = addr_q;
  assign sram_din   = din_q;
  assign rsp0_valid = s3_q.vld & (s3_q.tag == port_t'(0));
  assign rsp1_valid = s3_q.vld & (s3_q.tag == port_t'(1));
  assign rsp0_rdata = rd0_q;
  assign rsp1_rdata = rd1_q;
  assign busy       = s1_q.vld | s2_q.vld | s3_q.vld;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Randomized bench for sram_port_arbiter with a
// cycle-history reference model and a behavioural SRAM.
module tb_sram_port_arbiter;

  localparam int AW = 4;
  localparam int DW = 8;
  localparam int NCYC = 1200;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          req0_valid = 0, req1_valid = 0;
  logic          req0_we = 0, req1_we = 0;
  logic [AW-1:0] req0_addr = 0, req1_addr = 0;
  logic [DW-1:0] req0_wdata = 0, req1_wdata = 0;
  logic          req0_ready, req1_ready;
  logic          rsp0_valid, rsp1_valid;
  logic [DW-1:0] rsp0_rdata, rsp1_rdata;
  logic          sram_cs, sram_we;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_din, sram_dout;
  logic          busy;

  sram_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_we    (req0_we),
    .req0_addr  (req0_addr),
    .req0_wdata (req0_wdata),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_we    (req1_we),
    .req1_addr  (req1_addr),
    .req1_wdata (req1_wdata),
    .rsp0_valid (rsp0_valid),
    .rsp0_rdata (rsp0_rdata),
    .rsp1_valid (rsp1_valid),
    .rsp1_rdata (rsp1_rdata),
    .sram_cs    (sram_cs),
    .sram_we    (sram_we),
    .sram_addr  (sram_addr),
    .sram_din   (sram_din),
    .sram_dout  (sram_dout),
    .busy       (busy)
  );

  // Behavioural SRAM: registered read, dout only while cs & ~we
  logic [DW-1:0] sram_mem [16];
  logic [DW-1:0] dout_q = '0;
  always @(posedge clk) begin
    if (sram_cs && sram_we) sram_mem[sram_addr] <= sram_din;
    if (sram_cs && !sram_we) dout_q <= sram_mem[sram_addr];
  end
  assign sram_dout = (sram_cs && !sram_we) ? dout_q : 8'hEE;

  // Reference model state
  logic [DW-1:0] ref_mem [16];
  bit            h_acc  [NCYC];
  bit            h_we   [NCYC];
  bit            h_port [NCYC];
  logic [AW-1:0] h_addr [NCYC];
  logic [DW-1:0] h_dat  [NCYC];
  int            rst_cyc = -1;
  bit            ptr = 0;

  int errs = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp, input int cyc);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic bit ok(int k);
    return k > rst_cyc;
  endfunction

  function automatic bit rd_at(int k);
    return ok(k) && h_acc[k] && !h_we[k];
  endfunction

  initial begin
    bit            e_cs, e_we, e_busy, e_rv0, e_rv1, e_r0, e_r1;
    bit            s1rd, el0, el1;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_din;
    int            ph;

    for (int i = 0; i < 16; i++) begin
      sram_mem[i] = DW'(i * 8'h11);
      ref_mem[i]  = DW'(i * 8'h11);
    end

    for (int c = 0; c < NCYC; c++) begin
      @(posedge clk);
      #1;
      rst_n = !(c < 3 || $urandom_range(0, 99) == 0);
      ph = (c / 80) % 4;
      case (ph)
        0: begin
          req0_valid = $urandom_range(0, 3) != 0;
          req1_valid = $urandom_range(0, 3) != 0;
          req0_we = $urandom_range(0, 2) == 0;
          req1_we = $urandom_range(0, 2) == 0;
        end
        1: begin
          req0_valid = 1'b1;
          req1_valid = 1'b1;
          req0_we = 1'b0;
          req1_we = 1'b0;
        end
        2: begin
          req0_valid = $urandom_range(0, 1) != 0;
          req1_valid = $urandom_range(0, 1) != 0;
          req0_we = $urandom_range(0, 1) == 0;
          req1_we = $urandom_range(0, 3) != 0;
        end
        default: begin
          req0_valid = $urandom_range(0, 7) == 0;
          req1_valid = $urandom_range(0, 7) == 0;
          req0_we = $urandom_range(0, 1) == 0;
          req1_we = $urandom_range(0, 1) == 0;
        end
      endcase
      req0_addr  = AW'($urandom_range(0, 15));
      req1_addr  = AW'($urandom_range(0, 15));
      req0_wdata = DW'($urandom);
      req1_wdata = DW'($urandom);

      @(negedge clk);

      // Expected SRAM bus from recent acceptances
      e_cs = 0; e_we = 0; e_addr = '0; e_din = '0;
      if (ok(c - 1) && h_acc[c - 1]) begin
        e_cs   = 1;
        e_we   = h_we[c - 1];
        e_addr = h_addr[c - 1];
        e_din  = h_we[c - 1] ? h_dat[c - 1] : '0;
      end else if (rd_at(c - 2)) begin
        e_cs   = 1;
        e_addr = h_addr[c - 2];
      end
      e_rv0  = rd_at(c - 3) && !h_port[c - 3];
      e_rv1  = rd_at(c - 3) && h_port[c - 3];
      e_busy = (ok(c - 1) && h_acc[c - 1]) || rd_at(c - 2) || rd_at(c - 3);

      // Expected grant
      s1rd = rd_at(c - 1);
      el0 = rst_n && req0_valid && (!req0_we || !s1rd);
      el1 = rst_n && req1_valid && (!req1_we || !s1rd);
      e_r0 = el0 && (!el1 || !ptr);
      e_r1 = el1 && !e_r0;

      chk("ready0", 32'(req0_ready), 32'(e_r0), c);
      chk("ready1", 32'(req1_ready), 32'(e_r1), c);
      chk("cs", 32'(sram_cs), 32'(e_cs), c);
      chk("we", 32'(sram_we), 32'(e_we), c);
      chk("addr", 32'(sram_addr), 32'(e_addr), c);
      chk("din", 32'(sram_din), 32'(e_din), c);
      chk("busy", 32'(busy), 32'(e_busy), c);
      chk("rsp0_valid", 32'(rsp0_valid), 32'(e_rv0), c);
      chk("rsp1_valid", 32'(rsp1_valid), 32'(e_rv1), c);
      if (e_rv0) chk("rsp0_rdata", 32'(rsp0_rdata), 32'(h_dat[c - 3]), c);
      if (e_rv1) chk("rsp1_rdata", 32'(rsp1_rdata), 32'(h_dat[c - 3]), c);

      // Advance model
      h_acc[c] = 0;
      if (!rst_n) begin
        rst_cyc = c;
        ptr = 0;
      end else if (e_r0 || e_r1) begin
        h_acc[c]  = 1;
        h_port[c] = e_r1;
        h_we[c]   = e_r1 ? req1_we : req0_we;
        h_addr[c] = e_r1 ? req1_addr : req0_addr;
        if (h_we[c]) begin
          h_dat[c] = e_r1 ? req1_wdata : req0_wdata;
          ref_mem[h_addr[c]] = h_dat[c];
        end else begin
          h_dat[c] = ref_mem[h_addr[c]];
        end
        ptr = !e_r1;
      end
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/sram_port_arbiter.md
# sram_port_arbiter

Two-requester arbiter and sequencer for the single-port scratch SRAM that feeds the systolic array. It shares the SRAM's `cs`/`we`/`addr`/`din`/`dout` port between a loader and a reader using valid/ready requests. Reads are pipelined at one access per cycle. The block inserts the hold cycle the SRAM needs, because `dout` is only driven while `cs & ~we` is held. Read data returns to the originating port with a fixed latency.

## Interface
- `ADDR_WIDTH`, 4, SRAM address width
- `DATA_WIDTH`, 8, SRAM data width

Ports:
- `clk`  in  1  single clock, all logic on rising edge
- `rst_n`  in  1  synchronous reset, active-low
- `req0_valid` / `req1_valid`  in  1  request present
- `req0_ready` / `req1_ready`  out  1  request accepted this cycle when valid&ready
- `req0_we` / `req1_we`  in  1  1 = write, 0 = read
- `req0_addr` / `req1_addr`  in  ADDR_WIDTH  access address
- `req0_wdata` / `req1_wdata`  in  DATA_WIDTH  write data
- `rsp0_valid` / `rsp1_valid`  out  1  one-cycle read-data strobe
- `rsp0_rdata` / `rsp1_rdata`  out  DATA_WIDTH  read data, valid with strobe
- `sram_cs`, `sram_we`  out  1  SRAM chip select / write enable
- `sram_addr`  out  ADDR_WIDTH  SRAM address
- `sram_din`  out  DATA_WIDTH  SRAM write data
- `sram_dout`  in  DATA_WIDTH  SRAM read data (tristated when not reading)
- `busy`  out  1  any access in the S1/S2/S3 pipeline

## Operation
- Pipeline stages:
  - S1 issue: registered `sram_*` outputs, plus port tag.
  - S2 capture: a read issued last cycle; `sram_dout` is sampled this cycle.
  - S3 respond: registered rsp.
- Eligibility:
  - A read is always eligible.
  - A write is ineligible while S1 holds a read, because the next SRAM cycle must keep `cs=1, we=0` for capture.
- Arbitration among eligible valid requests is round-robin.
  - Pointer favours the port not granted last.
  - Pointer resets to favour port 0.
  - At most one ready per cycle; ready is combinational from valid, eligibility and pointer.
  - A ready is never given to an invalid port.
- S1 next state:
  - Accepted request: `cs=1`, `we=req_we`, `addr`, `din=wdata` (din=0 for reads).
  - No acceptance, S1 holds a read: hold cycle with `cs=1, we=0`, same addr, `din=0`. The re-read of the same address is harmless and is not forwarded.
  - Otherwise idle: all `sram_*` = 0.
- S2 captures `sram_dout` into the S3 rdata register for the tagged port. S3 pulses the matching `rspN_valid` for one cycle.
- Writes produce no response. Write data is committed at the end of its S1 cycle.
- Ordering: responses return in acceptance order. A read after a write to the same address returns the new data, since the write commits before the read's S1.
- Reset mid-operation:
  - In-flight reads are dropped with no rsp.
  - Pointer returns to port 0.
  - SRAM contents are untouched.

## Timing
- Reset values: every output 0. `req*_ready` is 0 while `rst_n=0`.
- Read accepted in cycle N:
  - cycle N+1: `sram_cs=1, we=0, addr`.
  - cycle N+2: `dout` sampled; `cs=1, we=0` guaranteed.
  - cycle N+3: `rspX_valid=1`.
  - Latency is 3 cycles.
- Write accepted in cycle N: SRAM write occurs in cycle N+1.
- Throughput:
  - Back-to-back reads, either port: 1 per cycle.
  - Read→read→write: write ready no earlier than 2 cycles after the last read acceptance (one bubble).
  - Write→read and write→write: no bubble.
- Simultaneous valid on both ports:
  - Both eligible: grant the port the pointer favours.
  - One port blocked (write behind a read): grant the other port.
- `busy` is the OR of the S1, S2 and S3 valid bits.

## Configuration
- `SRAM_ARB_FIXED_PRIO_EN` defined: fixed priority, port 0 always wins when eligible. The pointer logic is removed.
- Undefined: round-robin as above.

## Structure
- Shared package `sram_arb_pkg`:
  - `NUM_PORTS=2`.
  - Port-index typedef.
  - Stage-valid/tag struct for S1–S3.
- One sub-module, `rr_arb2`: 2-way round-robin arbiter with eligibility inputs. Its fixed-priority variant is selected by the macro.

## Test plan
- Port 0 writes 0xA5 to addr 3, then reads addr 3 → `sram_we` pulses in cycle N+1; `rsp0_valid` with 0xA5 three cycles after read acceptance.
- Both ports stream reads of addr 0..7 (preloaded with addr×0x11) → grants alternate 0,1,0,…; one SRAM read per cycle; each rsp carries the correct data on the correct port.
- Port 0 read addr 2 accepted, port 1 write same cycle+1 → port 1 ready held 0 for one cycle (hold cycle `cs=1, we=0, addr=2`); write then lands; port 0 data unaffected.
- Idle with no requests → `sram_cs=0`, `sram_addr=0`, `busy=0`; bus never written.
- `rst_n` asserted one cycle after a read acceptance → no `rsp*_valid` ever appears; all outputs 0 the cycle after reset; next grant goes to port 0.
- With `SRAM_ARB_FIXED_PRIO_EN`, both ports continuously requesting reads → port 1 never granted.
